// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS main control FSM
//
// Sequences each instruction through fetch, decode, execute, memory and
// writeback. Outputs are a Moore decode of the state, except pc_en/ir_write
// in FETCH (qualified by mem_ready) and pc_en in BRANCH (qualified by zero_flag).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode, funct       instruction fields from the instruction register
//   zero_flag           ALU zero result
//   mem_ready           memory has completed the current access
//   alu_op              ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   alu_src_a/b         ALU operand selects
//   pc_src, pc_en       PC next-value select and load enable
//   iord                memory address select (0 PC, 1 ALUOut)
//   mem_read/mem_write  memory requests
//   ir_write            instruction register load
//   reg_write, reg_dst  register file write and destination select
//   mem_to_reg          writeback data select
//   illegal_op          one-cycle pulse on an unsupported opcode/funct
//   state               current state, for debug

module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero_flag,
  input  logic               mem_ready,
  output logic [2:0]         alu_op,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_ADDIEX = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_ADDIWB = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(11);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [STATE_W-1:0] next_state;
  logic               funct_ok;
  logic [2:0]         funct_alu_op;
  logic               illegal_raw;
  logic               pc_en_raw, ir_write_raw, reg_write_raw;
  logic               mem_read_raw, mem_write_raw;

  always_comb begin
    funct_ok     = 1'b1;
    funct_alu_op = 3'b010;
    case (funct)
      6'b100000: funct_alu_op = 3'b010;
      6'b100010: funct_alu_op = 3'b110;
      6'b100100: funct_alu_op = 3'b000;
      6'b100101: funct_alu_op = 3'b001;
      6'b101010: funct_alu_op = 3'b111;
      default:   funct_ok     = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state    = S_FETCH;
    illegal_raw   = 1'b0;
    alu_op        = 3'b000;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    pc_en_raw     = 1'b0;
    iord          = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = 2'b01;
        alu_op       = 3'b010;
        ir_write_raw = mem_ready;
        pc_en_raw    = mem_ready;
        next_state   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        alu_src_b = 2'b11;
        alu_op    = 3'b010;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE: begin
            next_state  = funct_ok ? S_EXEC : S_FETCH;
            illegal_raw = !funct_ok;
          end
          OP_BEQ:  next_state = S_BRANCH;
          OP_ADDI: next_state = S_ADDIEX;
          OP_J:    next_state = S_JUMP;
          default: illegal_raw = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_op     = 3'b010;
        next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord         = 1'b1;
        mem_read_raw = 1'b1;
        next_state   = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      S_MEMWR: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
        next_state    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = funct_alu_op;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b110;
        pc_src    = 2'b01;
        pc_en_raw = zero_flag;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_op     = 3'b010;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
      S_JUMP: begin
        pc_src    = 2'b10;
        pc_en_raw = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // While reset is held the state already decodes as FETCH; the side-effecting
  // strobes are additionally masked so nothing is issued during reset.
  assign pc_en      = rst_n & pc_en_raw;
  assign ir_write   = rst_n & ir_write_raw;
  assign reg_write  = rst_n & reg_write_raw;
  assign mem_read   = rst_n & mem_read_raw;
  assign mem_write  = rst_n & mem_write_raw;
  assign illegal_op = rst_n & illegal_raw;

endmodule
